// File: rtl/sam_core_if.sv
// Request/wait memory port of sam_core: the core is the master, memory is the slave.
interface sam_core_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16
);
  logic              mem_req;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_wait;

  modport master (
    output mem_req, mem_rw, mem_addr, mem_wdata,
    input  mem_rdata, mem_wait
  );

  modport slave (
    input  mem_req, mem_rw, mem_addr, mem_wdata,
    output mem_rdata, mem_wait
  );
endinterface

// File: rtl/sam_core.sv
// Accumulator CPU with built-in fetch/decode/execute controller and registered memory port.
// Optional bus-timeout abort is compiled in with `define SAM_CORE_TIMEOUT_EN.
module sam_core #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned PC_STEP  = 2,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              reset,
  sam_core_if.master        bus,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ac,
  output logic              halted,
  output logic              bus_err
);

  localparam int unsigned EA_N = (ADDR_W < DATA_W - 3) ? ADDR_W : DATA_W - 3;

  if (DATA_W < 8 || TIMEOUT < 1) begin : g_param_check
    $error("sam_core: DATA_W must be >= 8 and TIMEOUT >= 1");
  end

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_OPREAD,
    S_WRITE,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    OP_LOAD  = 3'b000,
    OP_STORE = 3'b001,
    OP_ADD   = 3'b010,
    OP_SUB   = 3'b011,
    OP_AND   = 3'b100,
    OP_JUMP  = 3'b101,
    OP_JNEG  = 3'b110,
    OP_HALT  = 3'b111
  } op_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;
  logic [DATA_W-1:0] r_ac, w_ac_nxt;
  logic [DATA_W-1:0] r_ir, w_ir_nxt;
  logic              r_req, w_req_nxt;
  logic              r_rw, w_rw_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
  logic              r_halted, w_halted_nxt;

  op_t               w_op;
  logic [ADDR_W-1:0] w_ea;
  logic              w_done;

  assign w_op   = op_t'(r_ir[DATA_W-1:DATA_W-3]);
  assign w_done = r_req && !bus.mem_wait;

  // Operand address is zero-extended or truncated to the address width.
  always_comb begin
    w_ea = '0;
    for (int unsigned i = 0; i < EA_N; i++) begin
      w_ea[i] = r_ir[i];
    end
  end

`ifdef SAM_CORE_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] r_wcnt, w_wcnt_nxt;
  logic          r_bus_err, w_bus_err_nxt;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_FETCH;
      r_pc     <= ADDR_W'(RESET_PC);
      r_ac     <= '0;
      r_ir     <= '0;
      r_req    <= 1'b0;
      r_rw     <= 1'b1;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_halted <= 1'b0;
`ifdef SAM_CORE_TIMEOUT_EN
      r_wcnt    <= '0;
      r_bus_err <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_ac     <= w_ac_nxt;
      r_ir     <= w_ir_nxt;
      r_req    <= w_req_nxt;
      r_rw     <= w_rw_nxt;
      r_addr   <= w_addr_nxt;
      r_wdata  <= w_wdata_nxt;
      r_halted <= w_halted_nxt;
`ifdef SAM_CORE_TIMEOUT_EN
      r_wcnt    <= w_wcnt_nxt;
      r_bus_err <= w_bus_err_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_ac_nxt     = r_ac;
    w_ir_nxt     = r_ir;
    w_req_nxt    = r_req;
    w_rw_nxt     = r_rw;
    w_addr_nxt   = r_addr;
    w_wdata_nxt  = r_wdata;
    w_halted_nxt = r_halted;

    case (r_state)
      S_FETCH: begin
        // Only reached with req low straight after reset: launch the first fetch.
        if (!r_req) begin
          w_req_nxt  = 1'b1;
          w_rw_nxt   = 1'b1;
          w_addr_nxt = r_pc;
        end else if (w_done) begin
          w_ir_nxt    = bus.mem_rdata;
          w_pc_nxt    = r_pc + ADDR_W'(PC_STEP);
          w_req_nxt   = 1'b0;
          w_state_nxt = S_DECODE;
        end
      end

      S_DECODE: begin
        case (w_op)
          OP_LOAD, OP_ADD, OP_SUB, OP_AND: begin
            w_state_nxt = S_OPREAD;
            w_req_nxt   = 1'b1;
            w_rw_nxt    = 1'b1;
            w_addr_nxt  = w_ea;
          end
          OP_STORE: begin
            w_state_nxt = S_WRITE;
            w_req_nxt   = 1'b1;
            w_rw_nxt    = 1'b0;
            w_addr_nxt  = w_ea;
            w_wdata_nxt = r_ac;
          end
          OP_JUMP: begin
            w_pc_nxt    = w_ea;
            w_state_nxt = S_FETCH;
            w_req_nxt   = 1'b1;
            w_rw_nxt    = 1'b1;
            w_addr_nxt  = w_ea;
          end
          OP_JNEG: begin
            w_state_nxt = S_FETCH;
            w_req_nxt   = 1'b1;
            w_rw_nxt    = 1'b1;
            if (r_ac[DATA_W-1]) begin
              w_pc_nxt   = w_ea;
              w_addr_nxt = w_ea;
            end else begin
              w_addr_nxt = r_pc;
            end
          end
          default: begin
            w_state_nxt  = S_HALT;
            w_halted_nxt = 1'b1;
          end
        endcase
      end

      S_OPREAD: begin
        if (w_done) begin
          case (w_op)
            OP_LOAD: w_ac_nxt = bus.mem_rdata;
            OP_ADD:  w_ac_nxt = r_ac + bus.mem_rdata;
            OP_SUB:  w_ac_nxt = r_ac - bus.mem_rdata;
            OP_AND:  w_ac_nxt = r_ac & bus.mem_rdata;
            default: w_ac_nxt = r_ac;
          endcase
          w_state_nxt = S_FETCH;
          w_rw_nxt    = 1'b1;
          w_addr_nxt  = r_pc;
        end
      end

      S_WRITE: begin
        if (w_done) begin
          w_state_nxt = S_FETCH;
          w_rw_nxt    = 1'b1;
          w_addr_nxt  = r_pc;
        end
      end

      default: begin
        w_req_nxt = 1'b0;
      end
    endcase

`ifdef SAM_CORE_TIMEOUT_EN
    w_wcnt_nxt    = '0;
    w_bus_err_nxt = r_bus_err;
    // A stalled cycle never completes, so the abort leaves AC/PC/memory untouched.
    if (r_req && bus.mem_wait) begin
      if (r_wcnt == TW'(TIMEOUT - 1)) begin
        w_req_nxt     = 1'b0;
        w_bus_err_nxt = 1'b1;
        w_state_nxt   = S_HALT;
        w_halted_nxt  = 1'b1;
      end else begin
        w_wcnt_nxt = r_wcnt + 1'b1;
      end
    end
`endif
  end

  assign bus.mem_req   = r_req;
  assign bus.mem_rw    = r_rw;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;

  assign pc     = r_pc;
  assign ac     = r_ac;
  assign halted = r_halted;

`ifdef SAM_CORE_TIMEOUT_EN
  assign bus_err = r_bus_err;
`else
  assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_sam_core.sv
// Self-checking bench for sam_core: vector table, corner-case sequences and random programs vs an ISA model.
module tb_sam_core;

  logic        clk;
  logic        reset;
  logic        mem_wait;
  logic        ld;
  logic [15:0] pc;
  logic [15:0] ac;
  logic        halted;
  logic        bus_err;

  logic [15:0] mem   [256];
  logic [15:0] img   [256];
  logic [15:0] ref_m [256];
  bit          seen  [256];

  int          checks;
  int          errors;

  int          cnt, nwait, consec, tgt_left, wmode;
  bit          started, stab_en;
  logic        prev_req, prev_rw, prev_wait;
  logic [15:0] prev_addr, prev_wdata, tgt_addr;

  sam_core_if #(.DATA_W(16), .ADDR_W(16)) bus ();

  sam_core #(
    .DATA_W  (16),
    .ADDR_W  (16),
    .PC_STEP (2),
    .RESET_PC(0),
    .TIMEOUT (8)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .pc     (pc),
    .ac     (ac),
    .halted (halted),
    .bus_err(bus_err)
  );

  assign bus.mem_wait  = mem_wait;
  assign bus.mem_rdata = mem[bus.mem_addr[7:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld) mem <= img;
    else if (bus.mem_req && !bus.mem_wait && !bus.mem_rw) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
  end

  typedef struct {
    logic [15:0] op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_ac;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 16'h0000;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    mem_wait = 1'b0;
    #1;
    ld = 1'b1;
    @(posedge clk);
    #1 ld = 1'b0;
    prev_req = 1'b0; prev_wait = 1'b0; prev_rw = 1'b1;
    prev_addr = '0; prev_wdata = '0;
    started = 1'b0; cnt = 0; nwait = 0; consec = 0;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
  endtask

  // One cycle: sample after the edge, check hold-while-stalled, then drive mem_wait.
  task automatic step();
    logic w;
    @(negedge clk);
    if (started) cnt++;
    else if (bus.mem_req) begin started = 1'b1; cnt = 0; end
    if (stab_en && prev_req && prev_wait && !reset) begin
      chk("hold_req", bus.mem_req, 1'b1);
      chk("hold_addr", bus.mem_addr, prev_addr);
      chk("hold_rw", bus.mem_rw, prev_rw);
      if (!prev_rw) chk("hold_wdata", bus.mem_wdata, prev_wdata);
    end
    case (wmode)
      1:       w = bus.mem_req && consec < 3 && ($urandom_range(0, 2) == 0);
      2:       w = bus.mem_req && bus.mem_addr == tgt_addr && tgt_left > 0;
      3:       w = 1'b1;
      default: w = 1'b0;
    endcase
    if (wmode == 2 && w) tgt_left--;
    consec = w ? consec + 1 : 0;
    mem_wait = w;
    if (bus.mem_req && w) nwait++;
    if (bus.mem_req && bus.mem_rw && !w) seen[bus.mem_addr[7:0]] = 1'b1;
    prev_req = bus.mem_req; prev_rw = bus.mem_rw; prev_wait = w;
    prev_addr = bus.mem_addr; prev_wdata = bus.mem_wdata;
  endtask

  task automatic run_prog(input int budget);
    @(negedge clk) reset = 1'b0;
    for (int k = 0; k < budget && !halted; k++) step();
    chk("halt_reached", halted, 1'b1);
  endtask

  // ISA-level reference: executes ref_m, returns final pc/ac and zero-wait cycle count.
  task automatic model(output logic [15:0] m_pc, output logic [15:0] m_ac, output int lat);
    logic [15:0] ir, ea;
    m_pc = 0; m_ac = 0; lat = 0;
    for (int s = 0; s < 40; s++) begin
      ir = ref_m[m_pc[7:0]];
      m_pc = m_pc + 2;
      ea = {3'b000, ir[12:0]};
      case (ir[15:13])
        3'd0: begin m_ac = ref_m[ea[7:0]]; lat += 3; end
        3'd1: begin ref_m[ea[7:0]] = m_ac; lat += 3; end
        3'd2: begin m_ac = m_ac + ref_m[ea[7:0]]; lat += 3; end
        3'd3: begin m_ac = m_ac - ref_m[ea[7:0]]; lat += 3; end
        3'd4: begin m_ac = m_ac & ref_m[ea[7:0]]; lat += 3; end
        3'd5: begin m_pc = ea; lat += 2; end
        3'd6: begin if (m_ac[15]) m_pc = ea; lat += 2; end
        default: begin lat += 2; return; end
      endcase
    end
  endtask

  initial begin
    vec_t        vecs [6];
    logic [15:0] m_pc, m_ac;
    int          lat;
    logic [2:0]  op;

    checks = 0; errors = 0; ld = 1'b0; wmode = 0; stab_en = 1'b1;
    tgt_addr = '0; tgt_left = 0;

    vecs[0] = '{16'h4000, 16'h0005, 16'h0007, 16'h000C};
    vecs[1] = '{16'h6000, 16'h0003, 16'h0005, 16'hFFFE};
    vecs[2] = '{16'h8000, 16'hF0F0, 16'h3C3C, 16'h3030};
    vecs[3] = '{16'h4000, 16'hFFFF, 16'h0001, 16'h0000};
    vecs[4] = '{16'h0000, 16'h1111, 16'hBEEF, 16'hBEEF};
    vecs[5] = '{16'h6000, 16'h8000, 16'h0001, 16'h7FFF};

    // Reset state and first-fetch timing with a lone HALT at 0.
    clear_img();
    img[0] = 16'hE000;
    do_reset();
    chk("rst_req", bus.mem_req, 1'b0);
    chk("rst_rw", bus.mem_rw, 1'b1);
    chk("rst_addr", bus.mem_addr, 16'h0);
    chk("rst_wdata", bus.mem_wdata, 16'h0);
    chk("rst_pc", pc, 16'h0);
    chk("rst_ac", ac, 16'h0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_bus_err", bus_err, 1'b0);
    @(negedge clk) reset = 1'b0;
    step();
    chk("first_req", bus.mem_req, 1'b1);
    chk("first_addr", bus.mem_addr, 16'h0);
    step();
    chk("pc_after_fetch", pc, 16'h2);
    chk("decode_req", bus.mem_req, 1'b0);
    step();
    chk("halt_lat", halted, 1'b1);
    chk("halt_req", bus.mem_req, 1'b0);

    // Vector table: LOAD 0x20, <op> 0x22, STORE 0x24, HALT.
    for (int v = 0; v < 6; v++) begin
      clear_img();
      img[0] = 16'h0020; img[2] = vecs[v].op | 16'h0022;
      img[4] = 16'h2024; img[6] = 16'hE000;
      img[8'h20] = vecs[v].a; img[8'h22] = vecs[v].b;
      wmode = 0;
      do_reset();
      run_prog(60);
      chk($sformatf("vec%0d_ac", v), ac, vecs[v].exp_ac);
      chk($sformatf("vec%0d_mem", v), mem[8'h24], vecs[v].exp_ac);
      chk($sformatf("vec%0d_pc", v), pc, 16'h8);
      chk($sformatf("vec%0d_cycles", v), cnt, 11);
    end

    // SUB then JNEG taken: fetch 0x10 happens, fetch 0x6 does not.
    clear_img();
    img[0] = 16'h0020; img[2] = 16'h6022; img[4] = 16'hC010;
    img[6] = 16'hE000; img[8'h10] = 16'hE000;
    img[8'h20] = 16'h0003; img[8'h22] = 16'h0005;
    wmode = 0;
    do_reset();
    run_prog(60);
    chk("jneg_ac", ac, 16'hFFFE);
    chk("jneg_fetch10", seen[8'h10], 1'b1);
    chk("jneg_nofetch6", seen[8'h06], 1'b0);
    chk("jneg_pc", pc, 16'h12);

    // Four wait cycles on the ADD operand read stretch it to 7 cycles.
    clear_img();
    img[0] = 16'h0020; img[2] = 16'h4022; img[4] = 16'h2024; img[6] = 16'hE000;
    img[8'h20] = 16'h0005; img[8'h22] = 16'h0007;
    wmode = 2; tgt_addr = 16'h0022; tgt_left = 4;
    do_reset();
    run_prog(80);
    chk("wait_ac", ac, 16'h000C);
    chk("wait_cycles", cnt, 15);
    chk("wait_mem", mem[8'h24], 16'h000C);

    // Reset pulsed mid-write: request drops at once, target word untouched, refetch from 0.
    clear_img();
    img[0] = 16'h0020; img[2] = 16'h2024; img[4] = 16'hE000;
    img[8'h20] = 16'h1234; img[8'h24] = 16'hAAAA;
    wmode = 2; tgt_addr = 16'h0024; tgt_left = 6;
    do_reset();
    @(negedge clk) reset = 1'b0;
    for (int k = 0; k < 30 && !(bus.mem_req && !bus.mem_rw); k++) step();
    chk("wr_in_progress", bus.mem_req && !bus.mem_rw, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("async_req_drop", bus.mem_req, 1'b0);
    chk("async_pc", pc, 16'h0);
    @(negedge clk);
    chk("abandoned_write", mem[8'h24], 16'hAAAA);
    wmode = 0; prev_req = 1'b0; prev_wait = 1'b0;
    reset = 1'b0;
    step();
    chk("refetch_req", bus.mem_req, 1'b1);
    chk("refetch_addr", bus.mem_addr, 16'h0);
    for (int k = 0; k < 40 && !halted; k++) step();
    chk("rerun_halted", halted, 1'b1);
    chk("rerun_mem", mem[8'h24], 16'h1234);

    // Stuck wait on the first fetch.
    clear_img();
    img[0] = 16'h0020;
    wmode = 3; stab_en = 1'b0;
    do_reset();
    @(negedge clk) reset = 1'b0;
    step();
    repeat (7) step();
    chk("stuck7_req", bus.mem_req, 1'b1);
    chk("stuck7_bus_err", bus_err, 1'b0);
    step();
`ifdef SAM_CORE_TIMEOUT_EN
    chk("to_bus_err", bus_err, 1'b1);
    chk("to_halted", halted, 1'b1);
    chk("to_req", bus.mem_req, 1'b0);
    chk("to_pc", pc, 16'h0);
    chk("to_ac", ac, 16'h0);
`else
    chk("stuck_req", bus.mem_req, 1'b1);
    chk("stuck_bus_err", bus_err, 1'b0);
    chk("stuck_halted", halted, 1'b0);
`endif
    stab_en = 1'b1;

    // Random forward-branching programs with and without random stalls.
    for (int r = 0; r < 24; r++) begin
      clear_img();
      for (int i = 0; i < 8; i++) begin
        op = 3'($urandom_range(0, 7));
        if (op == 3'd5 || op == 3'd6)
          img[2*i] = {op, 13'(2 * $urandom_range(i + 1, 8))};
        else
          img[2*i] = {op, 13'(8'h40 + 2 * $urandom_range(0, 7))};
      end
      img[16] = 16'hE000;
      for (int k = 0; k < 8; k++) img[8'h40 + 2*k] = 16'($urandom);
      ref_m = img;
      model(m_pc, m_ac, lat);
      wmode = (r % 2 == 1) ? 1 : 0;
      do_reset();
      run_prog(200);
      chk($sformatf("rnd%0d_ac", r), ac, m_ac);
      chk($sformatf("rnd%0d_pc", r), pc, m_pc);
      chk($sformatf("rnd%0d_cycles", r), cnt, lat + nwait);
      for (int k = 0; k < 8; k++)
        chk($sformatf("rnd%0d_m%0h", r, 8'h40 + 2*k), mem[8'h40 + 2*k], ref_m[8'h40 + 2*k]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
